gpr_writeback: RTL and testbench
================================

# gpr_writeback

Write-side front end of the GPR register file: merges results from the execute unit (EX) and the load/store unit (LSU) onto the single GPR write port, one write per cycle. Also keeps a per-register busy scoreboard that the issue stage uses for RAW-hazard stalls. Sits between EX/LSU and GPR; its registered `rd_o`/`write_enable_o`/`data_o` drive GPR `rd_i`/`write_enable_i`/`data_i` directly.

## Interface
- `DATA_WIDTH`, 64, result and register width
- `RF_SIZE`, 5, register index width (2**RF_SIZE registers)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_valid_i`  in  1  EX result valid
- `ex_ready_o`  out  1  EX result accepted when high with `ex_valid_i`
- `ex_rd_i`  in  RF_SIZE  EX destination register
- `ex_data_i`  in  DATA_WIDTH  EX result
- `lsu_valid_i`  in  1  LSU result valid; no ready, always accepted
- `lsu_rd_i`  in  RF_SIZE  LSU destination register
- `lsu_data_i`  in  DATA_WIDTH  LSU load data
- `issue_valid_i`  in  1  issue stage dispatches an instruction writing `issue_rd_i`
- `issue_rd_i`  in  RF_SIZE  destination of dispatched instruction
- `issue_rd_busy_o`  out  1  `issue_rd_i` has a pending write; issue must not dispatch
- `rs1_i`, `rs2_i`  in  RF_SIZE  source registers probed by issue
- `rs1_busy_o`, `rs2_busy_o`  out  1  source has an unresolved pending write
- `rd_o`  out  RF_SIZE  GPR write index
- `write_enable_o`  out  1  GPR write strobe
- `data_o`  out  DATA_WIDTH  GPR write data

## Operation
- One-entry EX holding register (`hold_valid`, `hold_rd`, `hold_data`).
- `ex_ready_o = !hold_valid`. Purely a function of state, never of `lsu_valid_i`.
- Per-cycle source select, highest priority first:
  - LSU, if `lsu_valid_i`
  - hold, if `hold_valid`
  - EX input, if `ex_valid_i && ex_ready_o`
- EX handshake while LSU is selected: the EX result is captured into hold.
- Hold is cleared when hold is selected. It is not refilled in the same cycle, because `ex_ready_o` was low.
- Selected source is registered into `rd_o`/`data_o`. `write_enable_o <= selected && sel_rd != 0`.
- Results to x0 are consumed and dropped: `write_enable_o` stays 0. Index and data still load.
- Scoreboard `busy[2**RF_SIZE-1:0]`; `busy[0]` is hard-wired to 0.
  - Set on `issue_valid_i && issue_rd_i != 0`.
  - Cleared on `write_enable_o` for `rd_o`.
  - Same register set and cleared in one cycle: set wins.
- `rsN_busy_o = busy[rsN_i] && !(write_enable_o && rd_o == rsN_i)`. The write-first bypass in GPR supplies the data in that cycle.
- `issue_rd_busy_o = busy[issue_rd_i]`, without the bypass term. This forbids two outstanding writes to one register.
- Issue contract (checked by assertion, not by logic): `issue_valid_i` never asserts while `issue_rd_busy_o` is high.

## Timing
- Reset values: `ex_ready_o`=1 (hold empty), `write_enable_o`=0, `rd_o`=0, `data_o`=0, all busy=0, all busy outputs 0.
- Reset mid-operation drops the held EX result and clears the scoreboard. The pipeline must flush together with this block.
- Latency from handshake to write:
  - LSU: 1 cycle.
  - EX with no LSU conflict: 1 cycle.
  - EX deferred by LSU: 2 or more cycles, one extra per consecutive LSU cycle.
- Throughput: one GPR write per cycle. EX is sustained at 1/cycle only while LSU is idle.
- Hold full and LSU valid every cycle: `ex_ready_o` stays 0. LSU priority is absolute and no starvation guard is required.
- Busy bit clears on the edge that ends the `write_enable_o` cycle. The bypass term hides it one cycle earlier.

## Structure
- `rv_pkg`: `XLEN`=64, `REG_IDX_W`=5, `NUM_REGS`, and typedef `reg_idx_t`. Add `wb_src_e {WB_NONE, WB_LSU, WB_HOLD, WB_EX}` for the select mux.
- Sub-module `wb_skid`: the one-entry holding register with its valid/ready logic, reusable for other single-port producers.
- Scoreboard and output registers stay inline.

## Test plan
- EX only: `ex_rd_i`=5, data `0xDEAD_BEEF` in cycle 0 -> cycle 1: `write_enable_o`=1, `rd_o`=5, `data_o`=`0xDEAD_BEEF`; `ex_ready_o` stays 1.
- Conflict: LSU (rd 3, `0x11`) and EX (rd 4, `0x22`) in the same cycle -> next cycle writes x3=`0x11`, `ex_ready_o`=0; cycle after writes x4=`0x22`, `ex_ready_o`=1.
- LSU back-to-back for 4 cycles with EX valid -> exactly one EX accepted, `ex_ready_o`=0 for 4 cycles, EX write follows the last LSU write.
- Scoreboard: issue rd 7 -> `issue_rd_busy_o`(7)=1, `rs1_busy_o`(7)=1. EX result for x7 arrives -> `rs1_busy_o`=0 in the `write_enable_o` cycle; busy bit clear the next cycle.
- x0: issue rd 0 and EX result rd 0 -> busy stays 0, `write_enable_o` stays 0, `ex_ready_o` stays 1.
- Reset with hold full and busy[9]=1 -> after reset `ex_ready_o`=1, `rs1_busy_o`(9)=0, `write_enable_o`=0, and no write for the dropped entry.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared core constants and types for the GPR write-back path.
//                XLEN / REG_IDX_W set the default data and register-index
//                widths; wb_src_e names the write-port source chosen each
//                cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Source driving the GPR write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LSU  = 2'd1,
    WB_HOLD = 2'd2,
    WB_EX   = 2'd3
  } wb_src_e;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/gpr_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_writeback_if
//  Description : Bundle of every non-clock signal of gpr_writeback.
//                  EX     : ex_valid_i / ex_ready_o / ex_rd_i / ex_data_i
//                  LSU    : lsu_valid_i / lsu_rd_i / lsu_data_i (no ready)
//                  Issue  : issue_valid_i / issue_rd_i / issue_rd_busy_o,
//                           rs1_i / rs2_i / rs1_busy_o / rs2_busy_o
//                  GPR    : rd_o / write_enable_o / data_o
//                'slave' is the write-back block; 'master' is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpr_writeback_if
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int RF_SIZE    = REG_IDX_W
) ();

  logic                  ex_valid_i;
  logic                  ex_ready_o;
  logic [RF_SIZE-1:0]    ex_rd_i;
  logic [DATA_WIDTH-1:0] ex_data_i;

  logic                  lsu_valid_i;
  logic [RF_SIZE-1:0]    lsu_rd_i;
  logic [DATA_WIDTH-1:0] lsu_data_i;

  logic                  issue_valid_i;
  logic [RF_SIZE-1:0]    issue_rd_i;
  logic                  issue_rd_busy_o;
  logic [RF_SIZE-1:0]    rs1_i;
  logic [RF_SIZE-1:0]    rs2_i;
  logic                  rs1_busy_o;
  logic                  rs2_busy_o;

  logic [RF_SIZE-1:0]    rd_o;
  logic                  write_enable_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport slave (
    input  ex_valid_i, ex_rd_i, ex_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    output ex_ready_o, issue_rd_busy_o, rs1_busy_o, rs2_busy_o,
    output rd_o, write_enable_o, data_o
  );

  modport master (
    output ex_valid_i, ex_rd_i, ex_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    input  ex_ready_o, issue_rd_busy_o, rs1_busy_o, rs2_busy_o,
    input  rd_o, write_enable_o, data_o
  );

endinterface : gpr_writeback_if
`default_nettype wire

// File: rtl/wb_skid.sv
`default_nettype none
// ============================================================================
//  Module      : wb_skid
//  Description : One-entry holding register for a single-port producer that
//                shares a write port with a higher-priority source.
//                  i_valid / o_ready / i_data : producer handshake
//                  i_stall       : the shared port is taken by the other
//                                  source this cycle
//                  o_hold_valid / o_hold_data : parked entry, offered to the
//                                  port ahead of any new producer result
//                An entry is parked only when a handshake happens during a
//                stall; otherwise the producer result goes straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_skid #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_stall,
  output logic                  o_hold_valid,
  output logic [WIDTH-1:0]      o_hold_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;
  logic             w_drain;

  // Ready depends on state only, so the producer never sees a combinational
  // path from the competing source.
  assign o_ready   = !r_valid;
  assign w_capture = i_valid && !r_valid && i_stall;
  assign w_drain   = r_valid && !i_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_drain) begin
      // No refill in the drain cycle: o_ready was low, so nothing was accepted.
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= i_data;
    end
  end

  assign o_hold_valid = r_valid;
  assign o_hold_data  = r_data;

endmodule : wb_skid
`default_nettype wire

// File: rtl/gpr_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_writeback
//  Description : Write-side front end of the GPR file. Merges EX and LSU
//                results onto the single GPR write port (LSU first, then a
//                parked EX result, then a live EX result) and keeps the
//                per-register busy scoreboard used by issue for RAW stalls.
//                  clk, rst : clock, synchronous active-high reset
//                  bus      : gpr_writeback_if.slave (EX, LSU, issue probes,
//                             registered GPR write port)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_writeback
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int RF_SIZE    = REG_IDX_W
) (
  input  wire logic       clk,
  input  wire logic       rst,
  gpr_writeback_if.slave  bus
);

  localparam int c_NREGS = 1 << RF_SIZE;
  localparam int c_ENT_W = RF_SIZE + DATA_WIDTH;

  // --------------------------------------------------------------------------
  // EX holding register
  // --------------------------------------------------------------------------
  logic                  w_ex_ready;
  logic                  w_hold_valid;
  logic [c_ENT_W-1:0]    w_hold_ent;
  logic                  w_ex_fire;

  wb_skid #(
    .WIDTH (c_ENT_W)
  ) u_ex_skid (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (bus.ex_valid_i),
    .o_ready      (w_ex_ready),
    .i_data       ({bus.ex_rd_i, bus.ex_data_i}),
    .i_stall      (bus.lsu_valid_i),
    .o_hold_valid (w_hold_valid),
    .o_hold_data  (w_hold_ent)
  );

  assign w_ex_fire = bus.ex_valid_i && w_ex_ready;

  // --------------------------------------------------------------------------
  // Source select
  // --------------------------------------------------------------------------
  wb_src_e               w_sel;
  logic [RF_SIZE-1:0]    w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;

  always_comb begin
    w_sel      = WB_NONE;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (bus.lsu_valid_i) begin
      w_sel      = WB_LSU;
      w_sel_rd   = bus.lsu_rd_i;
      w_sel_data = bus.lsu_data_i;
    end else if (w_hold_valid) begin
      w_sel      = WB_HOLD;
      w_sel_rd   = w_hold_ent[c_ENT_W-1 -: RF_SIZE];
      w_sel_data = w_hold_ent[DATA_WIDTH-1:0];
    end else if (w_ex_fire) begin
      w_sel      = WB_EX;
      w_sel_rd   = bus.ex_rd_i;
      w_sel_data = bus.ex_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Registered GPR write port. Writes to x0 are consumed: index and data
  // still load, but the strobe stays low.
  // --------------------------------------------------------------------------
  logic                  r_we;
  logic [RF_SIZE-1:0]    r_rd;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= (w_sel != WB_NONE) && (w_sel_rd != '0);
      if (w_sel != WB_NONE) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard. Set on issue, cleared by the write strobe; set wins
  // when both hit one register. Bit 0 never holds a 1.
  // --------------------------------------------------------------------------
  logic [c_NREGS-1:0] r_busy;
  logic [c_NREGS-1:0] w_busy_set;
  logic [c_NREGS-1:0] w_busy_clr;
  logic [c_NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (bus.issue_valid_i && (bus.issue_rd_i != '0)) begin
      w_busy_set[bus.issue_rd_i] = 1'b1;
    end
    if (r_we) begin
      w_busy_clr[r_rd] = 1'b1;
    end
    w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= {w_busy_nxt[c_NREGS-1:1], 1'b0};
    end
  end

  // Source probes see a register as free in its write cycle: the GPR's
  // write-first bypass forwards the data. The destination probe has no such
  // bypass, which keeps at most one write outstanding per register.
  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_issue_rd_busy;

  assign w_rs1_busy      = r_busy[bus.rs1_i] && !(r_we && (r_rd == bus.rs1_i));
  assign w_rs2_busy      = r_busy[bus.rs2_i] && !(r_we && (r_rd == bus.rs2_i));
  assign w_issue_rd_busy = r_busy[bus.issue_rd_i];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ex_ready_o      = w_ex_ready;
  assign bus.rd_o            = r_rd;
  assign bus.write_enable_o  = r_we;
  assign bus.data_o          = r_data;
  assign bus.rs1_busy_o      = w_rs1_busy;
  assign bus.rs2_busy_o      = w_rs2_busy;
  assign bus.issue_rd_busy_o = w_issue_rd_busy;

  // Issue must never dispatch to a register with a write still pending.
  a_issue_contract : assert property (
    @(posedge clk) disable iff (rst) !(bus.issue_valid_i && w_issue_rd_busy)
  );

endmodule : gpr_writeback
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_writeback
//  Description : Directed self-checking bench for gpr_writeback. Inputs are
//                changed 1 ns after a rising edge; outputs are checked at
//                that same point, i.e. away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback;

  logic clk;
  logic rst;

  int n_vec;
  int n_miscmp;
  int n_acc;

  gpr_writeback_if #(.DATA_WIDTH(64), .RF_SIZE(5)) bus ();

  gpr_writeback #(
    .DATA_WIDTH (64),
    .RF_SIZE    (5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miscmp = n_miscmp + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid_i    = 1'b0;
    bus.ex_rd_i       = '0;
    bus.ex_data_i     = '0;
    bus.lsu_valid_i   = 1'b0;
    bus.lsu_rd_i      = '0;
    bus.lsu_data_i    = '0;
    bus.issue_valid_i = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    n_acc    = 0;
    idle();
    bus.issue_rd_i = 5'd5;
    bus.rs1_i      = 5'd5;
    bus.rs2_i      = 5'd6;

    // ---------------- reset state ----------------
    rst = 1'b1;
    tick();
    tick();
    check("rst_ex_ready", 64'(bus.ex_ready_o), 64'd1);
    check("rst_we", 64'(bus.write_enable_o), 64'd0);
    check("rst_rd", 64'(bus.rd_o), 64'd0);
    check("rst_data", bus.data_o, 64'd0);
    check("rst_rs1_busy", 64'(bus.rs1_busy_o), 64'd0);
    check("rst_rs2_busy", 64'(bus.rs2_busy_o), 64'd0);
    check("rst_issue_busy", 64'(bus.issue_rd_busy_o), 64'd0);
    rst = 1'b0;
    tick();

    // ---------------- EX only ----------------
    bus.ex_valid_i = 1'b1;
    bus.ex_rd_i    = 5'd5;
    bus.ex_data_i  = 64'hDEAD_BEEF;
    check("ex_ready_pre", 64'(bus.ex_ready_o), 64'd1);
    tick();
    idle();
    check("ex_we", 64'(bus.write_enable_o), 64'd1);
    check("ex_rd", 64'(bus.rd_o), 64'd5);
    check("ex_data", bus.data_o, 64'hDEAD_BEEF);
    check("ex_ready_post", 64'(bus.ex_ready_o), 64'd1);
    tick();
    check("ex_we_done", 64'(bus.write_enable_o), 64'd0);

    // ---------------- LSU/EX conflict ----------------
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = 5'd3;
    bus.lsu_data_i  = 64'h11;
    bus.ex_valid_i  = 1'b1;
    bus.ex_rd_i     = 5'd4;
    bus.ex_data_i   = 64'h22;
    check("cf_ready_with_lsu", 64'(bus.ex_ready_o), 64'd1);
    tick();
    idle();
    check("cf1_we", 64'(bus.write_enable_o), 64'd1);
    check("cf1_rd", 64'(bus.rd_o), 64'd3);
    check("cf1_data", bus.data_o, 64'h11);
    check("cf1_ready", 64'(bus.ex_ready_o), 64'd0);
    tick();
    check("cf2_we", 64'(bus.write_enable_o), 64'd1);
    check("cf2_rd", 64'(bus.rd_o), 64'd4);
    check("cf2_data", bus.data_o, 64'h22);
    check("cf2_ready", 64'(bus.ex_ready_o), 64'd1);
    tick();
    check("cf3_we", 64'(bus.write_enable_o), 64'd0);

    // ---------------- LSU back-to-back x4 with EX pending ----------------
    bus.ex_valid_i = 1'b1;
    bus.ex_rd_i    = 5'd20;
    bus.ex_data_i  = 64'hAA;
    for (int k = 0; k < 4; k++) begin
      bus.lsu_valid_i = 1'b1;
      bus.lsu_rd_i    = 5'(10 + k);
      bus.lsu_data_i  = 64'(256 + k);
      check($sformatf("b2b%0d_ready", k), 64'(bus.ex_ready_o), (k == 0) ? 64'd1 : 64'd0);
      if (bus.ex_valid_i && bus.ex_ready_o) n_acc = n_acc + 1;
      tick();
      check($sformatf("b2b%0d_we", k), 64'(bus.write_enable_o), 64'd1);
      check($sformatf("b2b%0d_rd", k), 64'(bus.rd_o), 64'(10 + k));
      check($sformatf("b2b%0d_data", k), bus.data_o, 64'(256 + k));
    end
    bus.lsu_valid_i = 1'b0;
    check("b2b4_ready", 64'(bus.ex_ready_o), 64'd0);
    if (bus.ex_valid_i && bus.ex_ready_o) n_acc = n_acc + 1;
    tick();
    idle();
    check("b2b_ex_we", 64'(bus.write_enable_o), 64'd1);
    check("b2b_ex_rd", 64'(bus.rd_o), 64'd20);
    check("b2b_ex_data", bus.data_o, 64'hAA);
    check("b2b_ready_back", 64'(bus.ex_ready_o), 64'd1);
    check("b2b_accepts", 64'(n_acc), 64'd1);
    tick();
    check("b2b_we_done", 64'(bus.write_enable_o), 64'd0);

    // ---------------- scoreboard ----------------
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd7;
    bus.rs1_i         = 5'd7;
    bus.rs2_i         = 5'd7;
    check("sb_issue_busy_pre", 64'(bus.issue_rd_busy_o), 64'd0);
    tick();
    bus.issue_valid_i = 1'b0;
    check("sb_issue_busy", 64'(bus.issue_rd_busy_o), 64'd1);
    check("sb_rs1_busy", 64'(bus.rs1_busy_o), 64'd1);
    check("sb_rs2_busy", 64'(bus.rs2_busy_o), 64'd1);
    bus.ex_valid_i = 1'b1;
    bus.ex_rd_i    = 5'd7;
    bus.ex_data_i  = 64'h77;
    tick();
    idle();
    check("sb_wr_we", 64'(bus.write_enable_o), 64'd1);
    check("sb_wr_rd", 64'(bus.rd_o), 64'd7);
    check("sb_wr_rs1_bypass", 64'(bus.rs1_busy_o), 64'd0);
    check("sb_wr_issue_busy", 64'(bus.issue_rd_busy_o), 64'd1);
    tick();
    check("sb_clr_issue_busy", 64'(bus.issue_rd_busy_o), 64'd0);
    check("sb_clr_rs1", 64'(bus.rs1_busy_o), 64'd0);
    check("sb_clr_we", 64'(bus.write_enable_o), 64'd0);

    // ---------------- x0 destination ----------------
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd0;
    bus.rs1_i         = 5'd0;
    bus.ex_valid_i    = 1'b1;
    bus.ex_rd_i       = 5'd0;
    bus.ex_data_i     = 64'h55;
    tick();
    idle();
    check("x0_we", 64'(bus.write_enable_o), 64'd0);
    check("x0_rd", 64'(bus.rd_o), 64'd0);
    check("x0_data", bus.data_o, 64'h55);
    check("x0_ready", 64'(bus.ex_ready_o), 64'd1);
    check("x0_issue_busy", 64'(bus.issue_rd_busy_o), 64'd0);
    check("x0_rs1_busy", 64'(bus.rs1_busy_o), 64'd0);
    tick();

    // ---------------- reset with hold full and busy[9] ----------------
    bus.lsu_valid_i   = 1'b1;
    bus.lsu_rd_i      = 5'd1;
    bus.lsu_data_i    = 64'h1;
    bus.ex_valid_i    = 1'b1;
    bus.ex_rd_i       = 5'd2;
    bus.ex_data_i     = 64'h2;
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd9;
    bus.rs1_i         = 5'd9;
    tick();
    idle();
    check("mr_pre_ready", 64'(bus.ex_ready_o), 64'd0);
    check("mr_pre_busy9", 64'(bus.issue_rd_busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_ready", 64'(bus.ex_ready_o), 64'd1);
    check("mr_rs1_busy9", 64'(bus.rs1_busy_o), 64'd0);
    check("mr_issue_busy9", 64'(bus.issue_rd_busy_o), 64'd0);
    check("mr_we", 64'(bus.write_enable_o), 64'd0);
    tick();
    check("mr_no_drop_write", 64'(bus.write_enable_o), 64'd0);
    tick();
    check("mr_no_drop_write2", 64'(bus.write_enable_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule : tb_gpr_writeback
`default_nettype wire
